// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its picker.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int GID_W         = $clog2(NUM_REQ_DEF);
  localparam int BCNT_W        = $clog2(MAX_BURST_DEF + 1);

  // Grant index width; never narrower than one bit.
  function automatic int gid_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int bcnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from last_grant+1, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Walk from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(last_grant) + i) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ burst producers,
// with full-flag beat stall and optional almost-full grant stall.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 8,
  parameter int ALM_STALL = 1,
  localparam int ID_W     = gid_w(NUM_REQ),
  localparam int CNT_W    = bcnt_w(MAX_BURST)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  input  logic                        fifo_alm_full,
  output logic                        fifo_wren,
  output logic [DATA_W-1:0]           fifo_wrdata,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              accept, burst_end, can_grant, ld_grant;

  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy      = (state == XFER);
  assign accept    = busy & sel_valid & ~fifo_full;
  // last flag and beat limit on the same beat collapse into one end event
  assign burst_end = accept & (sel_last | (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)));
  assign can_grant = pick_found & ~fifo_full & ~((ALM_STALL != 0) & fifo_alm_full);

  always_comb begin
    state_nxt = state;
    ld_grant  = 1'b0;
    case (state)
      IDLE: if (can_grant) begin
        state_nxt = XFER;
        ld_grant  = 1'b1;
      end
      XFER: if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready follows fifo_full combinationally so a full FIFO is never written.
  always_comb begin
    req_ready = '0;
    if (busy) begin
      for (int i = 0; i < NUM_REQ; i++)
        req_ready[i] = (grant_id == ID_W'(i)) & ~fifo_full;
    end
    fifo_wren   = accept;
    fifo_wrdata = busy ? sel_data : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (ld_grant) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (burst_end) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: producer queues drive the ports, a scoreboard
// monitor checks every FIFO write against the expected beat order.
module tb_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_alm_full = 1'b0;
  logic              fifo_wren;
  logic [DW-1:0]     fifo_wrdata;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(8), .ALM_STALL(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_alm_full(fifo_alm_full), .fifo_wren(fifo_wren),
    .fifo_wrdata(fifo_wrdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         pq[NR][$];
  logic [DW-1:0] exp_q[$];
  logic          full_nxt = 1'b0;
  logic          alm_nxt = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int tag, input int p, input int b);
    return {64'(tag), 32'(p), 32'(b)};
  endfunction

  task automatic load(input int tag, input int p, input int n, input int n_exp);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.d = mk(tag, p, b);
      bt.l = (b == n - 1);
      pq[p].push_back(bt);
      if (b < n_exp) exp_q.push_back(bt.d);
    end
  endtask

  task automatic drive();
    fifo_full     = full_nxt;
    fifo_alm_full = alm_nxt;
    for (int p = 0; p < NR; p++) begin
      if (pq[p].size() > 0) begin
        req_valid[p]           = 1'b1;
        req_last[p]            = pq[p][0].l;
        req_data[p*DW +: DW]   = pq[p][0].d;
      end else begin
        req_valid[p]           = 1'b0;
        req_last[p]            = 1'b0;
        req_data[p*DW +: DW]   = '0;
      end
    end
  endtask

  // Inputs change on the falling edge; a beat is taken by the producer model
  // when valid&ready are both high going into the next rising edge.
  task automatic tick();
    @(negedge clk);
    drive();
    #1;
    for (int p = 0; p < NR; p++)
      if (rstn && req_valid[p] && req_ready[p]) void'(pq[p].pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    for (int p = 0; p < NR; p++) pq[p].delete();
    exp_q.delete();
    full_nxt = 1'b0;
    alm_nxt  = 1'b0;
    drive();
    @(negedge clk);
    #3 rstn = 1'b1;
  endtask

  task automatic drain(input string nm);
    int  k;
    logic pend;
    k = 0;
    pend = 1'b1;
    while (pend && k < 200) begin
      tick();
      k++;
      pend = (exp_q.size() != 0);
      for (int p = 0; p < NR; p++) if (pq[p].size() != 0) pend = 1'b1;
    end
    tick();
    tick();
    chk({nm, "_drain_timeout"}, DW'(k < 200), DW'(1));
    chk({nm, "_exp_left"}, DW'(exp_q.size()), DW'(0));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    #2;
    if (rstn && fifo_wren) begin
      chk("wr_while_full", DW'(fifo_full), DW'(0));
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_wrdata);
      end else begin
        chk("wrdata", fifo_wrdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();

    // reset values with no requests
    tick();
    chk("rst_busy", DW'(busy), 0);
    chk("rst_ready", DW'(req_ready), 0);
    chk("rst_wren", DW'(fifo_wren), 0);
    chk("rst_wrdata", fifo_wrdata, 0);
    chk("rst_gid", DW'(grant_id), 0);

    // single producer, 3-beat burst
    load(1, 0, 3, 3);
    tick();
    chk("t1_idle", DW'(busy), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_wren", DW'(fifo_wren), 1);
      chk("t1_ready", DW'(req_ready), DW'(4'b0001));
    end
    tick();
    chk("t1_busy_end", DW'(busy), 0);
    chk("t1_wren_end", DW'(fifo_wren), 0);
    drain("t1");

    // all producers, 2-beat bursts: grant order 0,1,2,3,0 with one idle gap
    do_reset();
    for (int p = 0; p < NR; p++) load(2, p, 2, 2);
    load(20, 0, 2, 2);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t2_busy", DW'(busy), DW'(k % 3 != 0));
      if (k % 3 == 1) chk("t2_gid", DW'(grant_id), DW'((k / 3) % 4));
    end
    drain("t2");

    // 12-beat burst truncated at 8, producer 2 interleaves, then 4 more
    do_reset();
    load(3, 1, 12, 0);
    load(3, 2, 2, 0);
    for (int b = 0; b < 8; b++) exp_q.push_back(mk(3, 1, b));
    for (int b = 0; b < 2; b++) exp_q.push_back(mk(3, 2, b));
    for (int b = 8; b < 12; b++) exp_q.push_back(mk(3, 1, b));
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k == 1)  chk("t3_gid_a", DW'(grant_id), 1);
      if (k == 8)  chk("t3_beat8", DW'(fifo_wren), 1);
      if (k == 9)  chk("t3_gap_a", DW'(busy), 0);
      if (k == 10) chk("t3_gid_b", DW'(grant_id), 2);
      if (k == 12) chk("t3_gap_b", DW'(busy), 0);
      if (k == 13) chk("t3_gid_c", DW'(grant_id), 1);
    end
    drain("t3");

    // fifo_full for 3 cycles mid-burst
    do_reset();
    load(4, 0, 6, 6);
    for (int k = 0; k < 3; k++) tick();
    full_nxt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_ready_full", DW'(req_ready), 0);
      chk("t4_wren_full", DW'(fifo_wren), 0);
      chk("t4_busy_full", DW'(busy), 1);
    end
    full_nxt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_wren_resume", DW'(fifo_wren), 1);
    end
    drain("t4");

    // almost-full stalls a new grant but not a running burst
    do_reset();
    alm_nxt = 1'b1;
    load(5, 0, 4, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_alm_nogrant", DW'(busy), 0);
    end
    alm_nxt = 1'b0;
    tick();
    chk("t5_fall_same", DW'(busy), 0);
    tick();
    chk("t5_grant", DW'(busy), 1);
    chk("t5_wren0", DW'(fifo_wren), 1);
    alm_nxt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_alm_cont", DW'(fifo_wren), 1);
    end
    alm_nxt = 1'b0;
    drain("t5");

    // reset mid-burst, then producer 0 wins over producer 1
    do_reset();
    load(6, 0, 4, 1);
    load(6, 1, 2, 0);
    tick();
    tick();
    @(negedge clk);
    drive();
    rstn = 1'b0;
    #1;
    chk("t6_busy", DW'(busy), 0);
    chk("t6_ready", DW'(req_ready), 0);
    chk("t6_wren", DW'(fifo_wren), 0);
    chk("t6_wrdata", fifo_wrdata, 0);
    chk("t6_gid", DW'(grant_id), 0);
    chk("t6_exp_empty", DW'(exp_q.size()), 0);
    for (int p = 0; p < NR; p++) pq[p].delete();
    @(negedge clk);
    #3 rstn = 1'b1;
    load(16, 0, 4, 4);
    load(16, 1, 2, 2);
    tick();
    tick();
    chk("t6_regrant_busy", DW'(busy), 1);
    chk("t6_regrant_gid", DW'(grant_id), 0);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer presents a valid/ready burst interface; the arbiter grants one producer at a time, forwards its beats onto the FIFO write port, and ends the burst on a last flag or at a beat limit. It sits directly in front of the FIFO and uses the FIFO's full and almost-full flags for backpressure.

## Interface
- NUM_REQ, 4, number of producers (2..16)
- DATA_W, 128, data width, equals FIFO data width
- MAX_BURST, 8, maximum beats per grant (1..256)
- ALM_STALL, 1, when 1 a new grant is not issued while fifo_alm_full is high

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-producer beat valid
- req_last  in  NUM_REQ  per-producer last beat of burst
- req_data  in  NUM_REQ*DATA_W  per-producer data; producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-producer beat accepted
- fifo_full  in  1  FIFO full flag
- fifo_alm_full  in  1  FIFO almost-full flag
- fifo_wren  out  1  FIFO write enable
- fifo_wrdata  out  DATA_W  FIFO write data
- grant_id  out  clog2(NUM_REQ)  currently or last granted producer
- busy  out  1  high while in XFER

## Operation
- FSM: IDLE, XFER.
- IDLE: if any req_valid, fifo_full low, and (ALM_STALL=0 or fifo_alm_full low), select the first valid producer searching upward from last_grant+1 (mod NUM_REQ). Register grant_id, clear beat_cnt, go to XFER. Otherwise stay.
- XFER: req_ready[grant_id] = !fifo_full; all other ready bits 0. A beat is accepted when req_valid[grant_id] & req_ready[grant_id]. fifo_wren = accept; fifo_wrdata = req_data of grant_id (combinational mux).
- Each accepted beat increments beat_cnt (width clog2(MAX_BURST+1)).
- Burst ends on an accepted beat with req_last[grant_id]=1 or beat_cnt+1 == MAX_BURST. On end: last_grant <= grant_id, return to IDLE.
- Valid low during XFER: hold grant and wait, with no timeout.
- fifo_alm_full during XFER does not stop the burst. Only fifo_full stalls it.
- Non-granted producers must hold valid and data; the arbiter never drops or reorders beats within a producer.
- A burst truncated by MAX_BURST continues as a new burst at the producer's next grant.

## Timing
- Reset values: state IDLE, req_ready 0, fifo_wren 0, fifo_wrdata 0 (mux output gated by busy), grant_id 0, busy 0, last_grant NUM_REQ-1 (producer 0 has first priority), beat_cnt 0.
- Grant latency: request seen in IDLE at cycle t -> busy and req_ready high at t+1. The first write occurs at t+1 if fifo_full is low.
- Throughput: one beat per cycle within a burst. Exactly one IDLE cycle between consecutive bursts.
- fifo_full rising: ready drops in the same cycle (combinational), so there is no write to a full FIFO.
- Last beat accepted at cycle t -> busy low at t+1. Re-arbitration in IDLE at t+1, next grant at t+2.
- Reset asserted mid-burst: everything returns to reset values immediately. The partial burst is abandoned, and the producer must restart after reset.
- req_last and beat limit in the same beat: a single end event, with no double update.

## Structure
- Shared package fifo_pkg: state enum (IDLE, XFER) and clog2-based width constants (GID_W, BCNT_W).
- One sub-module, rr_pick: combinational round-robin picker with inputs req vector and last_grant, outputs found and index. It is reusable by other arbiters.
- Top level holds the FSM, beat counter, grant register and data mux.

## Test plan
- Single producer 0, 3-beat burst (D0..D2, last on D2), FIFO not full -> fifo_wren high for 3 consecutive cycles starting 1 cycle after valid, data D0,D1,D2, busy low the next cycle.
- All 4 producers valid continuously with 2-beat bursts, after reset -> grant order 0,1,2,3,0; one idle cycle between bursts.
- Producer 1 with a 12-beat burst, MAX_BURST=8 -> first grant writes 8 beats. Producer 2 (valid) is granted next, then producer 1 resumes with 4 beats.
- fifo_full forced high for 3 cycles mid-burst -> req_ready and fifo_wren low for exactly those cycles, no beat lost, order preserved.
- ALM_STALL=1 with fifo_alm_full high in IDLE and producer 0 valid -> no grant. fifo_alm_full falls -> grant next cycle. alm_full rising mid-burst -> burst continues.
- rstn pulsed low during beat 2 of a 4-beat burst -> outputs at reset values within the same cycle. After release, producer 0 is granted first.
